// File: rtl/cpu_mem_map.sv
// CPU-side address decoder for a cartridge-style memory map: internal RAM, PPU registers,
// PRG RAM, banked PRG ROM and a 5-bit serial bank-register port written through the ROM window.
module cpu_mem_map #(
  parameter int RAM_AW      = 11,
  parameter int PRG_BANK_AW = 14,
  parameter int PRG_BANKS   = 8,
  parameter int PRG_RAM_EN  = 1,
  localparam int BW         = $clog2(PRG_BANKS),
  localparam int PA         = PRG_BANK_AW + BW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic              WE,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              ppu_reg_cs,
  output logic [2:0]        ppu_reg_addr,
  input  logic [7:0]        ppu_data_in,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_WE,
  input  logic [7:0]        ram_q,
  output logic [12:0]       prgram_addr,
  output logic              prgram_WE,
  input  logic [7:0]        prgram_q,
  output logic [PA-1:0]     rom_addr,
  input  logic [7:0]        rom_q,
  output logic [4:0]        chr_bank0,
  output logic [4:0]        chr_bank1,
  output logic              chr_mode
);

  localparam logic [2:0] REG_OPEN   = 3'd0;
  localparam logic [2:0] REG_RAM    = 3'd1;
  localparam logic [2:0] REG_PPU    = 3'd2;
  localparam logic [2:0] REG_PRGRAM = 3'd3;
  localparam logic [2:0] REG_ROM    = 3'd4;

  logic [2:0] region;
  logic       is_ram;
  logic       is_ppu;
  logic       is_prgram;
  logic       is_rom;
  logic       prgram_en;

  logic [4:0] control_reg;
  logic [4:0] chr_bank0_reg;
  logic [4:0] chr_bank1_reg;
  logic [4:0] prg_reg;
  logic [4:0] shift_reg;
  logic [2:0] count_reg;
  logic       ignore_reg;

  logic [2:0] region_reg;
  logic [7:0] ppu_q_reg;
  logic [7:0] hold_reg;

  logic       serial_wr;
  logic [4:0] shift_next;
  logic [4:0] bank_sel;

  // Mirroring bits are carried in control but not consumed by this block.
  logic unused_bits;
  assign unused_bits = &{1'b0, control_reg[1:0], data_in[6:1]};

  always_comb begin
    region = REG_OPEN;
    case (addr[15:13])
      3'b000:  region = REG_RAM;
      3'b001:  region = REG_PPU;
      3'b010:  region = REG_OPEN;
      3'b011:  region = REG_PRGRAM;
      default: region = REG_ROM;
    endcase
  end

  assign is_ram    = (region == REG_RAM);
  assign is_ppu    = (region == REG_PPU);
  assign is_prgram = (region == REG_PRGRAM);
  assign is_rom    = (region == REG_ROM);
  assign prgram_en = (PRG_RAM_EN != 0) && !prg_reg[4];

  assign ram_addr     = addr[RAM_AW-1:0];
  assign ram_WE       = WE & is_ram;
  assign ppu_reg_cs   = is_ppu;
  assign ppu_reg_addr = addr[2:0];
  assign prgram_addr  = addr[12:0];
  assign prgram_WE    = WE & is_prgram & prgram_en;

  // addr[14] picks the $8000 or $C000 half of the ROM window.
  always_comb begin
    bank_sel = 5'd0;
    case (control_reg[3:2])
      2'd2:    bank_sel = addr[14] ? {1'b0, prg_reg[3:0]} : 5'd0;
      2'd3:    bank_sel = addr[14] ? 5'(PRG_BANKS - 1) : {1'b0, prg_reg[3:0]};
      default: bank_sel = {1'b0, prg_reg[3:1], addr[14]};
    endcase
  end

  assign rom_addr = {bank_sel[BW-1:0], addr[PRG_BANK_AW-1:0]};

  assign chr_bank0 = chr_bank0_reg;
  assign chr_bank1 = chr_bank1_reg;
  assign chr_mode  = control_reg[4];

  // A write landing right after an accepted serial write is dropped entirely.
  assign serial_wr  = WE & is_rom & ~ignore_reg;
  assign shift_next = {data_in[0], shift_reg[4:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      control_reg   <= 5'h0C;
      chr_bank0_reg <= 5'd0;
      chr_bank1_reg <= 5'd0;
      prg_reg       <= 5'd0;
      shift_reg     <= 5'd0;
      count_reg     <= 3'd0;
      ignore_reg    <= 1'b0;
    end else begin
      ignore_reg <= serial_wr;
      if (serial_wr) begin
        if (data_in[7]) begin
          shift_reg   <= 5'd0;
          count_reg   <= 3'd0;
          control_reg <= control_reg | 5'h0C;
        end else if (count_reg == 3'd4) begin
          case (addr[14:13])
            2'd0:    control_reg   <= shift_next;
            2'd1:    chr_bank0_reg <= shift_next;
            2'd2:    chr_bank1_reg <= shift_next;
            default: prg_reg       <= shift_next;
          endcase
          shift_reg <= 5'd0;
          count_reg <= 3'd0;
        end else begin
          shift_reg <= shift_next;
          count_reg <= count_reg + 3'd1;
        end
      end
    end
  end

  // A disabled PRG RAM window reads like open bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      region_reg <= REG_OPEN;
      ppu_q_reg  <= 8'h00;
      hold_reg   <= 8'h00;
    end else begin
      region_reg <= (is_prgram && !prgram_en) ? REG_OPEN : region;
      ppu_q_reg  <= ppu_data_in;
      hold_reg   <= data_out;
    end
  end

  always_comb begin
    data_out = hold_reg;
    case (region_reg)
      REG_RAM:    data_out = ram_q;
      REG_PPU:    data_out = ppu_q_reg;
      REG_PRGRAM: data_out = prgram_q;
      REG_ROM:    data_out = rom_q;
      default:    data_out = hold_reg;
    endcase
  end

endmodule

// File: tb/tb_cpu_mem_map.sv
// Directed bench for cpu_mem_map with behavioural RAM, PRG RAM and ROM models.
module tb_cpu_mem_map;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        WE;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        ppu_reg_cs;
  logic [2:0]  ppu_reg_addr;
  logic [7:0]  ppu_data_in;
  logic [10:0] ram_addr;
  logic        ram_WE;
  logic [7:0]  ram_q;
  logic [12:0] prgram_addr;
  logic        prgram_WE;
  logic [7:0]  prgram_q;
  logic [16:0] rom_addr;
  logic [7:0]  rom_q;
  logic [4:0]  chr_bank0;
  logic [4:0]  chr_bank1;
  logic        chr_mode;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram_mem [0:2047];
  logic [7:0] prg_mem [0:8191];

  always #5 clk = ~clk;

  cpu_mem_map dut (
    .clk(clk), .reset(reset), .addr(addr), .WE(WE), .data_in(data_in),
    .data_out(data_out), .ppu_reg_cs(ppu_reg_cs), .ppu_reg_addr(ppu_reg_addr),
    .ppu_data_in(ppu_data_in), .ram_addr(ram_addr), .ram_WE(ram_WE), .ram_q(ram_q),
    .prgram_addr(prgram_addr), .prgram_WE(prgram_WE), .prgram_q(prgram_q),
    .rom_addr(rom_addr), .rom_q(rom_q), .chr_bank0(chr_bank0), .chr_bank1(chr_bank1),
    .chr_mode(chr_mode)
  );

  always @(posedge clk) begin
    if (ram_WE) ram_mem[ram_addr] <= data_in;
    ram_q <= ram_mem[ram_addr];
    if (prgram_WE) prg_mem[prgram_addr] <= data_in;
    prgram_q <= prg_mem[prgram_addr];
    rom_q <= rom_addr[7:0] ^ {3'b000, rom_addr[16:12]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE = 1'b0;
    addr = 16'h4000;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_in = d; WE = 1'b1;
    step();
    idle();
  endtask

  // Serial writes separated by an idle cycle so none is ignored.
  task automatic serial_bit(input logic [15:0] a, input logic [7:0] d);
    cpu_write(a, d);
    step();
  endtask

  task automatic serial_value(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) serial_bit(a, {7'b0, v[i]});
  endtask

  task automatic cpu_read(input logic [15:0] a);
    addr = a; WE = 1'b0;
    step();
    idle();
  endtask

  task automatic check_rom(input string tag, input logic [15:0] a, input logic [31:0] exp);
    addr = a; WE = 1'b0;
    #1;
    check(tag, 32'(rom_addr), exp);
    idle();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram_mem[i] = 8'h00;
    for (int i = 0; i < 8192; i++) prg_mem[i] = 8'h00;
    reset = 1'b1; addr = 16'h4000; WE = 1'b0; data_in = 8'h00; ppu_data_in = 8'h00;
    step(); step();
    check("reset_data_out", 32'(data_out), 32'h00);
    check("reset_chr_bank0", 32'(chr_bank0), 32'h00);
    check("reset_chr_bank1", 32'(chr_bank1), 32'h00);
    check("reset_chr_mode", 32'(chr_mode), 32'h0);
    reset = 1'b0;
    step();
    check_rom("reset_rom_c000", 16'hC000, 32'd114688);
    addr = 16'h0000; #1;
    check("ram_no_ppu_cs", 32'(ppu_reg_cs), 32'h0);

    addr = 16'h0005; data_in = 8'h5A; WE = 1'b1; #1;
    check("ram_we", 32'(ram_WE), 32'h1);
    check("ram_addr", 32'(ram_addr), 32'h005);
    step(); idle();
    cpu_read(16'h0805);
    check("ram_mirror_read", 32'(data_out), 32'h5A);

    addr = 16'h3FFA; ppu_data_in = 8'h80; #1;
    check("ppu_cs", 32'(ppu_reg_cs), 32'h1);
    check("ppu_reg_addr", 32'(ppu_reg_addr), 32'h2);
    step(); idle(); ppu_data_in = 8'h00;
    check("ppu_read", 32'(data_out), 32'h80);
    step();
    check("open_bus_hold", 32'(data_out), 32'h80);

    cpu_write(16'h6010, 8'h77);
    cpu_read(16'h6010);
    check("prgram_read", 32'(data_out), 32'h77);

    serial_value(16'hE000, 5'd5);
    check_rom("prg5_8000", 16'h8000, 32'd81920);
    check_rom("prg5_c000_fixed", 16'hC000, 32'd114688);
    cpu_read(16'h8003);
    check("rom_read", 32'(data_out), 32'h17);

    serial_value(16'hE000, 5'h15);
    check_rom("prg15_8000", 16'h8000, 32'd81920);
    addr = 16'h6010; data_in = 8'h33; WE = 1'b1; #1;
    check("prgram_we_disabled", 32'(prgram_WE), 32'h0);
    step(); idle();
    cpu_read(16'h0805);
    cpu_read(16'h6010);
    check("prgram_disabled_hold", 32'(data_out), 32'h5A);

    serial_value(16'h8000, 5'd2);
    check_rom("mode0_c000", 16'hC000, 32'd81920);
    check_rom("mode0_8000", 16'h8000, 32'd65536);

    // Second write of each pair lands in the ignore cycle.
    addr = 16'hA000; data_in = 8'h01; WE = 1'b1; step();
    data_in = 8'h80; step(); idle(); step();
    serial_bit(16'hA000, 8'h00); serial_bit(16'hA000, 8'h01);
    serial_bit(16'hA000, 8'h00); serial_bit(16'hA000, 8'h00);
    check("ignored_reset_chr0", 32'(chr_bank0), 32'h05);
    check_rom("ignored_reset_mode", 16'hC000, 32'd81920);

    addr = 16'hC000; data_in = 8'h01; WE = 1'b1; step();
    data_in = 8'h01; step(); idle(); step();
    serial_bit(16'hC000, 8'h00); serial_bit(16'hC000, 8'h01);
    serial_bit(16'hC000, 8'h00); serial_bit(16'hC000, 8'h00);
    check("ignored_shift_chr1", 32'(chr_bank1), 32'h05);

    serial_bit(16'h8000, 8'h01); serial_bit(16'h8000, 8'h01); serial_bit(16'h8000, 8'h01);
    serial_bit(16'h8000, 8'h80);
    check_rom("reset_bit_mode3_c000", 16'hC000, 32'd114688);
    check_rom("reset_bit_mode3_8000", 16'h8000, 32'd81920);
    serial_value(16'hC000, 5'd3);
    check("count_cleared_chr1", 32'(chr_bank1), 32'h03);

    serial_value(16'h8000, 5'h18);
    check("chr_mode_set", 32'(chr_mode), 32'h1);
    check_rom("mode2_8000", 16'h8000, 32'd0);
    check_rom("mode2_c000", 16'hC000, 32'd81920);

    serial_bit(16'h8000, 8'h01); serial_bit(16'h8000, 8'h01); serial_bit(16'h8000, 8'h01);
    reset = 1'b1; step(); step(); reset = 1'b0;
    check("midreset_data_out", 32'(data_out), 32'h00);
    check("midreset_chr_mode", 32'(chr_mode), 32'h0);
    serial_value(16'h8000, 5'd2);
    check("after_reset_chr_mode", 32'(chr_mode), 32'h0);
    check_rom("after_reset_c000", 16'hC000, 32'd16384);
    check_rom("after_reset_8000", 16'h8000, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_mem_map.md
CPU_MEM_MAP -- requirements
Module: cpu_mem_map

Interface
REQ-001 Parameter RAM_AW, default 11: internal CPU RAM address width; RAM occupies $0000-$1FFF, mirrored every 2^RAM_AW bytes.
REQ-002 Parameter PRG_BANK_AW, default 14: PRG ROM bank size is 2^PRG_BANK_AW bytes.
REQ-003 Parameter PRG_BANKS, default 8: number of 16 KB PRG banks; must be a power of two, 2..32.
REQ-004 Parameter PRG_RAM_EN, default 1: 1 enables the $6000-$7FFF PRG RAM window.
REQ-005 Derived width: PA = PRG_BANK_AW + clog2(PRG_BANKS).
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 addr  in  16  CPU address.
REQ-009 WE  in  1  CPU write strobe, one cycle per write.
REQ-010 data_in  in  8  CPU write data.
REQ-011 data_out  out  8  CPU read data, valid one cycle after addr.
REQ-012 ppu_reg_cs  out  1  PPU register select, combinational.
REQ-013 ppu_reg_addr  out  3  PPU register index = addr[2:0].
REQ-014 ppu_data_in  in  8  PPU register read data.
REQ-015 ram_addr, ram_WE, ram_q  out RAM_AW / out 1 / in 8  CPU RAM port; synchronous memory with 1-cycle read latency.
REQ-016 prgram_addr, prgram_WE, prgram_q  out 13 / out 1 / in 8  PRG RAM port; same timing.
REQ-017 rom_addr, rom_q  out PA / in 8  PRG ROM port; same timing.
REQ-018 chr_bank0, chr_bank1, chr_mode  out 5 / out 5 / out 1  CHR banking state for the PPU side.

Function
REQ-019 Decode: $0000-$1FFF RAM; $2000-$3FFF PPU (mirror every 8); $4000-$5FFF open bus; $6000-$7FFF PRG RAM; $8000-$FFFF PRG ROM.
REQ-020 ram_addr = addr[RAM_AW-1:0]; ram_WE = WE & RAM region.
REQ-021 ppu_reg_cs = 1 iff addr in PPU region, regardless of WE.
REQ-022 prgram_WE = WE & PRG RAM region & PRG_RAM_EN & ~prg_reg[4].
REQ-023 Read path: region and ppu_data_in registered at cycle N; data_out at N+1 muxes ram_q, prgram_q, rom_q or the registered PPU byte.
REQ-024 Open-bus region, or PRG RAM disabled: data_out holds its previous value.
REQ-025 Serial bank port: CPU write to $8000-$FFFF with data_in[7]=1 clears shift register to empty (count=0) and ORs control with 0x0C, all in the same cycle.
REQ-026 Write with data_in[7]=0: data_in[0] shifts in LSB-first; the 5th write loads the 5-bit value into the register selected by addr[14:13] (0 control, 1 chr_bank0, 2 chr_bank1, 3 prg_reg), then clears count to 0.
REQ-027 A ROM-region write in the cycle immediately after an accepted serial write is ignored entirely; no shift, no reset.
REQ-028 control[1:0] is mirroring (unused here); control[4] drives chr_mode.
REQ-029 PRG mode control[3:2]: 0/1 = 32 KB at $8000, bank = {prg_reg[3:1],0}; 2 = bank 0 fixed at $8000, prg_reg[3:0] at $C000; 3 = prg_reg[3:0] at $8000, bank PRG_BANKS-1 fixed at $C000.
REQ-030 Effective bank number taken modulo PRG_BANKS; rom_addr = {bank, addr[PRG_BANK_AW-1:0]}.
REQ-031 A bank register update takes effect for reads addressed in the next cycle.

Reset
REQ-032 On reset: shift register empty, count=0, control=0x0C, chr_bank0=chr_bank1=0, prg_reg=0, data_out=0x00, ignore-flag clear, registered region = open bus.
REQ-033 Reset asserted mid-sequence discards partial shift data; the first write after release counts as write 1.

Verification
REQ-034 Reset, read $0805 after writing 0x5A to $0005 -> data_out=0x5A one cycle after addr (mirror).
REQ-035 Read $3FFA -> ppu_reg_cs=1, ppu_reg_addr=2; ppu_data_in=0x80 -> data_out=0x80 next cycle.
REQ-036 Five writes of 1,0,1,0,0 (non-consecutive cycles) to $E000 -> prg_reg=5; read $8000 -> rom_addr=5*16384; read $C000 -> bank 7 (PRG_BANKS=8).
REQ-037 Two ROM writes on back-to-back cycles -> only the first shifts (count=1); write 0x80 after 3 shifts -> count=0, control[3:2]=3.
REQ-038 prg_reg[4]=1, write 0x33 to $6000 -> prgram_WE=0; read $6000 -> data_out unchanged.
REQ-039 Reset asserted after 3 shifts, then 5 writes of value 2's bits to $8000 -> control=2 (mode 0, 32 KB), $C000 read maps to bank {prg_reg[3:1],1}.
